// File: rtl/uart_cmd_wrapper_if.sv
// Byte/command/response signal bundle around the UART command framer.
// slave is the framer's view, master the UART/command-processor side.
interface uart_cmd_wrapper_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        tx_busy;
  logic        resp_sent;
  logic        frame_err;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy,
    input  resp, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy,
    output trmt, tx_data, tx_busy,
    output resp_sent, frame_err
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy,
    output resp, send_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy,
    input  trmt, tx_data, tx_busy,
    input  resp_sent, frame_err
  );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// Frames UART RX bytes into 16-bit commands (hi byte first, with
// inter-byte timeout) and sequences one response byte into UART TX.
module uart_cmd_wrapper #(
  parameter int TIMEOUT = 2_500_000
) (
  input logic clk,
  input logic rst,
  uart_cmd_wrapper_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic {WAIT_HI, WAIT_LO} rx_st_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_st_t;

  rx_st_t r_rx_st, w_rx_nxt;
  tx_st_t r_tx_st, w_tx_nxt;

  logic [CW-1:0] r_cnt;
  logic [7:0]    r_hi;
  logic [15:0]   r_cmd;
  logic          r_cmd_rdy;
  logic          r_trmt;
  logic [7:0]    r_tx_data;
  logic          r_resp_sent;
  logic          r_done_q;

  logic w_hi_cap, w_lo_cap, w_tmo;
  logic w_tx_start, w_tx_end;

  always_comb begin
    w_rx_nxt = r_rx_st;
    w_hi_cap = 1'b0;
    w_lo_cap = 1'b0;
    w_tmo    = 1'b0;
    unique case (r_rx_st)
      WAIT_HI: if (bus.rx_rdy) begin
        w_hi_cap = 1'b1;
        w_rx_nxt = WAIT_LO;
      end
      WAIT_LO: if (bus.rx_rdy) begin
        w_lo_cap = 1'b1;
        w_rx_nxt = WAIT_HI;
      end else if (r_cnt == TMAX) begin
        w_tmo    = 1'b1;
        w_rx_nxt = WAIT_HI;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_tx_nxt   = r_tx_st;
    w_tx_start = 1'b0;
    w_tx_end   = 1'b0;
    unique case (r_tx_st)
      TX_IDLE: if (bus.send_resp) begin
        w_tx_start = 1'b1;
        w_tx_nxt   = TX_BUSY;
      end
      TX_BUSY: if (bus.tx_done && !r_done_q) begin
        w_tx_end = 1'b1;
        w_tx_nxt = TX_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_st     <= WAIT_HI;
      r_tx_st     <= TX_IDLE;
      r_cnt       <= '0;
      r_hi        <= 8'h00;
      r_cmd       <= 16'h0000;
      r_cmd_rdy   <= 1'b0;
      r_trmt      <= 1'b0;
      r_tx_data   <= 8'h00;
      r_resp_sent <= 1'b0;
      r_done_q    <= 1'b0;
    end else begin
      r_rx_st <= w_rx_nxt;
      r_tx_st <= w_tx_nxt;
      if (w_hi_cap) begin
        r_hi  <= bus.rx_data;
        r_cnt <= '0;
      end else if (w_tmo) begin
        r_hi <= 8'h00;
      end else if (r_rx_st == WAIT_LO && !w_lo_cap) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // a completed command outranks a same-cycle clear
      if (w_lo_cap) begin
        r_cmd     <= {r_hi, bus.rx_data};
        r_cmd_rdy <= 1'b1;
      end else if (w_hi_cap || bus.clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
      if (w_tx_start) r_tx_data <= bus.resp;
      r_trmt      <= w_tx_start;
      r_resp_sent <= w_tx_end;
      r_done_q    <= bus.tx_done;
    end
  end

  assign bus.clr_rx_rdy = bus.rx_rdy & ~rst;
  assign bus.frame_err  = w_tmo & ~rst;
  assign bus.cmd        = r_cmd;
  assign bus.cmd_rdy    = r_cmd_rdy;
  assign bus.trmt       = r_trmt;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_busy    = (r_tx_st == TX_BUSY);
  assign bus.resp_sent  = r_resp_sent;
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: expected commands, tx bytes,
// frame errors and resp_sent pulses are queued at drive time.
module tb_uart_cmd_wrapper;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_wrapper_if bus();

  uart_cmd_wrapper #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] v;
    int          c;
  } exp_t;

  exp_t q_cmd[$];
  exp_t q_tx[$];
  int   q_frm[$];
  int   q_sent[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  bit          m_lo = 0;
  bit          m_busy = 0;
  int          m_hi_cyc = 0;
  logic [7:0]  m_hi = 8'h00;
  logic        m_done_prev = 1'b0;

  task automatic step();
    if (rst) begin
      m_lo   = 0;
      m_busy = 0;
    end else begin
      if (bus.rx_rdy) begin
        if (!m_lo) begin
          m_hi     = bus.rx_data;
          m_hi_cyc = cyc;
          m_lo     = 1;
        end else begin
          q_cmd.push_back('{{m_hi, bus.rx_data}, cyc + 1});
          m_lo = 0;
        end
      end else if (m_lo && cyc == m_hi_cyc + TO) begin
        q_frm.push_back(cyc);
        m_lo = 0;
      end
      if (bus.send_resp && !m_busy) begin
        q_tx.push_back('{{8'h00, bus.resp}, cyc + 1});
        m_busy = 1;
      end else if (m_busy && bus.tx_done && !m_done_prev) begin
        q_sent.push_back(cyc + 1);
        m_busy = 0;
      end
    end
    m_done_prev = bus.tx_done;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    step();
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_cmd"}, bus.cmd, 0);
    check({tag, "_cmd_rdy"}, bus.cmd_rdy, 0);
    check({tag, "_trmt"}, bus.trmt, 0);
    check({tag, "_tx_data"}, bus.tx_data, 0);
    check({tag, "_tx_busy"}, bus.tx_busy, 0);
    check({tag, "_resp_sent"}, bus.resp_sent, 0);
    check({tag, "_frame_err"}, bus.frame_err, 0);
  endtask

  logic p_cmd_rdy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.rx_rdy || rst)
      check("clr_rx_rdy", bus.clr_rx_rdy, bus.rx_rdy & ~rst);
    if (bus.cmd_rdy && !p_cmd_rdy) begin
      if (q_cmd.size() == 0) check("cmd_unexpected", 1, 0);
      else begin
        e = q_cmd.pop_front();
        check("cmd", bus.cmd, e.v);
        check("cmd_cycle", cyc, e.c);
      end
    end
    p_cmd_rdy <= bus.cmd_rdy;
    if (bus.frame_err) begin
      if (q_frm.size() == 0) check("frame_unexpected", 1, 0);
      else check("frame_cycle", cyc, q_frm.pop_front());
    end
    if (bus.trmt) begin
      if (q_tx.size() == 0) check("trmt_unexpected", 1, 0);
      else begin
        e = q_tx.pop_front();
        check("tx_data", bus.tx_data, e.v);
        check("trmt_cycle", cyc, e.c);
      end
    end
    if (bus.resp_sent) begin
      if (q_sent.size() == 0) check("sent_unexpected", 1, 0);
      else check("sent_cycle", cyc, q_sent.pop_front());
    end
  end

  initial begin
    bus.rx_rdy      = 1'b0;
    bus.rx_data     = 8'h00;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.send_resp   = 1'b0;
    bus.tx_done     = 1'b0;
    rst = 1'b1;
    #1;
    idle(2);
    chk_zero("rst");
    rst = 1'b0;

    // basic two-byte command, then processor clear
    send(8'hA5);
    idle(5);
    send(8'h3C);
    check("cmd_rdy_set", bus.cmd_rdy, 1);
    bus.clr_cmd_rdy = 1'b1;
    step();
    bus.clr_cmd_rdy = 1'b0;
    check("cmd_rdy_clr", bus.cmd_rdy, 0);
    check("cmd_hold", bus.cmd, 16'hA53C);

    // timeout discards 8'h12
    send(8'h12);
    idle(20);
    send(8'h34);
    send(8'h56);
    check("cmd_after_tmo", bus.cmd, 16'h3456);

    // low byte exactly in the timeout cycle
    send(8'h77);
    idle(TO - 1);
    send(8'h88);
    check("cmd_edge", bus.cmd, 16'h7788);
    check("cmd_rdy_edge", bus.cmd_rdy, 1);

    // new high byte while cmd_rdy, then set beats clear
    send(8'hAB);
    check("cmd_rdy_drop", bus.cmd_rdy, 0);
    check("cmd_old", bus.cmd, 16'h7788);
    idle(3);
    check("cmd_old2", bus.cmd, 16'h7788);
    bus.clr_cmd_rdy = 1'b1;
    send(8'hCD);
    bus.clr_cmd_rdy = 1'b0;
    check("set_wins", bus.cmd_rdy, 1);
    check("cmd_abcd", bus.cmd, 16'hABCD);

    // response path
    bus.resp      = 8'hA5;
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    check("tx_busy_on", bus.tx_busy, 1);
    bus.resp      = 8'hFF;
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    check("tx_data_hold", bus.tx_data, 8'hA5);
    idle(27);
    bus.tx_done = 1'b1;
    step();
    check("tx_busy_off", bus.tx_busy, 0);
    bus.resp      = 8'h5A;
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    bus.tx_done   = 1'b0;
    check("tx_busy_b2b", bus.tx_busy, 1);
    check("tx_data_b2b", bus.tx_data, 8'h5A);
    idle(5);
    bus.tx_done = 1'b1;
    idle(3);
    check("tx_busy_end", bus.tx_busy, 0);

    // reset mid-command and mid-transmission
    bus.tx_done = 1'b0;
    send(8'h42);
    bus.resp      = 8'hC3;
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    idle(2);
    rst = 1'b1;
    step();
    chk_zero("rst2");
    rst = 1'b0;
    bus.tx_done = 1'b1;
    idle(TO + 4);
    send(8'h9A);
    send(8'hBC);
    check("cmd_post_rst", bus.cmd, 16'h9ABC);
    idle(3);

    check("q_cmd_empty", q_cmd.size(), 0);
    check("q_tx_empty", q_tx.size(), 0);
    check("q_frm_empty", q_frm.size(), 0);
    check("q_sent_empty", q_sent.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
